rsm_mem_io: RTL and testbench

- Parametrised memory and memory-mapped I/O subsystem for the Simple RISC Machine top level.
- Contains a RAM of configurable width and depth, plus a LED output register, a HEX display register and a synchronised switch input port, all on one address space.
- Every access completes through a command/ready handshake with a configurable number of wait states, so the CPU stalls on slow memory.

---
 rtl/rsm_mem_io.sv | 150 +++++++++++++++
 tb/tb_rsm_mem_io.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsm_mem_io.sv
// Memory and memory-mapped I/O for the Simple RISC Machine: RAM, LED, HEX and switch
// port behind one address space, accessed via a cmd/ready handshake with wait states.
module rsm_mem_io #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 9,
    parameter int                RAM_AW      = 8,
    parameter int                LED_W       = 10,
    parameter int                SW_W        = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR    = 9'h100,
    parameter logic [ADDR_W-1:0] HEX_ADDR    = 9'h120,
    parameter logic [ADDR_W-1:0] SW_ADDR     = 9'h140,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  ledr,
    output logic [DATA_W-1:0] hex_data,
    output logic              err
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [LED_W-1:0]    r_ledr;
    logic [DATA_W-1:0]   r_hex;
    logic                r_err;
    logic [SW_W-1:0]     r_sw_meta;
    logic [SW_W-1:0]     r_sw_sync;
    logic [DATA_W-1:0]   r_ram [RAM_DEPTH];

    logic                w_cmd_valid;
    logic                w_fire;
    logic                w_sel_ram;
    logic                w_sel_led;
    logic                w_sel_hex;
    logic                w_sel_sw;
    logic                w_unmapped;
    logic [DATA_W-1:0]   w_led_ext;
    logic [DATA_W-1:0]   w_sw_ext;
    logic [DATA_W-1:0]   w_rd_val;

    assign w_cmd_valid = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);
    assign w_fire      = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // Decode always uses the latched address so the CPU may change mem_addr mid-access.
    assign w_sel_ram   = (r_addr[ADDR_W-1:RAM_AW] == '0);
    assign w_sel_led   = (r_addr == LED_ADDR);
    assign w_sel_hex   = (r_addr == HEX_ADDR);
    assign w_sel_sw    = (r_addr == SW_ADDR);
    assign w_unmapped  = !(w_sel_ram || w_sel_led || w_sel_hex || w_sel_sw);

    always_comb begin
        w_led_ext              = '0;
        w_led_ext[LED_W-1:0]   = r_ledr;
        w_sw_ext               = '0;
        w_sw_ext[SW_W-1:0]     = r_sw_sync;
        w_rd_val               = '0;
        if (w_sel_ram)
            w_rd_val = r_ram[r_addr[RAM_AW-1:0]];
        else if (w_sel_led)
            w_rd_val = w_led_ext;
        else if (w_sel_hex)
            w_rd_val = r_hex;
        else if (w_sel_sw)
            w_rd_val = w_sw_ext;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_valid) w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    assign busy      = (r_state == S_WAIT);
    assign mem_ready = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_ledr    <= '0;
            r_hex     <= '0;
            r_err     <= 1'b0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (r_state == S_IDLE && w_cmd_valid) begin
                r_wr    <= (mem_cmd == 2'b10);
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire) begin
                if (w_unmapped)
                    r_err <= 1'b1;
                if (r_wr) begin
                    if (w_sel_led) r_ledr <= r_wdata[LED_W-1:0];
                    if (w_sel_hex) r_hex  <= r_wdata;
                end else begin
                    r_rdata <= w_rd_val;
                end
            end
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_fire && r_wr && w_sel_ram)
            r_ram[r_addr[RAM_AW-1:0]] <= r_wdata;
    end

    assign mem_rdata = r_rdata;
    assign ledr      = r_ledr;
    assign hex_data  = r_hex;
    assign err       = r_err;

endmodule

// File: tb/tb_rsm_mem_io.sv
// Directed bench for rsm_mem_io: three instances with 0, 3 and 4 wait states share clk and reset.
module tb_rsm_mem_io;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd   [3];
    logic [8:0]  addr  [3];
    logic [15:0] wdata [3];
    logic [7:0]  sw    [3];
    logic [15:0] rdata [3];
    logic        ready [3];
    logic        busy  [3];
    logic [9:0]  ledr  [3];
    logic [15:0] hex   [3];
    logic        err   [3];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    rsm_mem_io #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n), .mem_cmd(cmd[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]), .mem_ready(ready[0]), .busy(busy[0]), .sw(sw[0]),
        .ledr(ledr[0]), .hex_data(hex[0]), .err(err[0]));

    rsm_mem_io #(.WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(rst_n), .mem_cmd(cmd[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]), .mem_ready(ready[1]), .busy(busy[1]), .sw(sw[1]),
        .ledr(ledr[1]), .hex_data(hex[1]), .err(err[1]));

    rsm_mem_io #(.WAIT_CYCLES(4)) dut2 (
        .clk(clk), .reset(rst_n), .mem_cmd(cmd[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_rdata(rdata[2]), .mem_ready(ready[2]), .busy(busy[2]), .sw(sw[2]),
        .ledr(ledr[2]), .hex_data(hex[2]), .err(err[2]));

    // Issue one command at a negedge; lat counts negedges from acceptance until ready is seen.
    task automatic do_access(input int k, input logic [1:0] c, input logic [8:0] a,
                             input logic [15:0] d, output int lat, output int bcnt,
                             output logic [15:0] rd);
        lat  = 0;
        bcnt = 0;
        rd   = '0;
        cmd[k] = c; addr[k] = a; wdata[k] = d;
        @(negedge clk);
        cmd[k] = 2'b00;
        lat = 1;
        while (ready[k] !== 1'b1 && lat < 40) begin
            if (busy[k] === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout dut%0d addr=%h: ready=%b after %0d cycles, required 1", k, a, ready[k], lat);
            lat = -1;
        end
        rd = rdata[k];
        @(negedge clk);
        vectors++;
        if (ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL ready_width dut%0d addr=%h: ready=%b one cycle later, required 0", k, a, ready[k]);
        end
        $display("dut%0d cmd=%b addr=%h wdata=%h -> rdata=%h lat=%0d busy_cycles=%0d err=%b",
                 k, c, a, d, rd, lat, bcnt, err[k]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({rdata[k], ready[k], busy[k], ledr[k], hex[k], err[k]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdata=%h ready=%b busy=%b ledr=%h hex=%h err=%b, required all 0",
                         k, rdata[k], ready[k], busy[k], ledr[k], hex[k], err[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_ram_rw();
        int lat, bc;
        logic [15:0] rd;
        do_access(0, 2'b10, 9'h010, 16'hBEEF, lat, bc, rd);
        vectors++;
        if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d, required 2", lat); end
        do_access(0, 2'b01, 9'h010, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL ram_read: got %h, required BEEF", rd); end
        vectors++;
        if (lat !== 2 || bc !== 1) begin errors++; $display("FAIL read_latency: lat=%0d busy=%0d, required 2/1", lat, bc); end
        do_access(0, 2'b10, 9'h011, 16'h1357, lat, bc, rd);
        vectors++;
        if (rdata[0] !== 16'hBEEF) begin errors++; $display("FAIL rdata_hold: got %h, required BEEF", rdata[0]); end
    endtask

    task automatic test_wait_states();
        int lat, bc;
        logic [15:0] rd;
        int extra;
        do_access(1, 2'b10, 9'h000, 16'h1111, lat, bc, rd);
        do_access(1, 2'b01, 9'h000, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h1111) begin errors++; $display("FAIL ws_read: got %h, required 1111", rd); end
        vectors++;
        if (lat !== 5) begin errors++; $display("FAIL ws_latency: got %0d, required 5", lat); end
        vectors++;
        if (bc !== 4) begin errors++; $display("FAIL ws_busy_cycles: got %0d, required 4", bc); end
        // Second command arrives mid-access and must be dropped.
        cmd[1] = 2'b10; addr[1] = 9'h000; wdata[1] = 16'h2222;
        @(negedge clk);
        cmd[1] = 2'b00;
        @(negedge clk);
        cmd[1] = 2'b10; wdata[1] = 16'h3333;
        @(negedge clk);
        cmd[1] = 2'b00;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (ready[1] === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 1) begin errors++; $display("FAIL ignored_cmd_ready: %0d pulses, required 1", extra); end
        do_access(1, 2'b01, 9'h000, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h2222) begin errors++; $display("FAIL ignored_cmd_data: got %h, required 2222", rd); end
    endtask

    task automatic test_mmio();
        int lat, bc;
        logic [15:0] rd;
        do_access(0, 2'b10, 9'h100, 16'hFFFF, lat, bc, rd);
        vectors++;
        if (ledr[0] !== 10'h3FF) begin errors++; $display("FAIL led_write: got %h, required 3FF", ledr[0]); end
        do_access(0, 2'b10, 9'h120, 16'h1234, lat, bc, rd);
        vectors++;
        if (hex[0] !== 16'h1234) begin errors++; $display("FAIL hex_write: got %h, required 1234", hex[0]); end
        do_access(0, 2'b01, 9'h100, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h03FF) begin errors++; $display("FAIL led_read: got %h, required 03FF", rd); end
        do_access(0, 2'b01, 9'h120, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h1234) begin errors++; $display("FAIL hex_read: got %h, required 1234", rd); end
    endtask

    task automatic test_switch();
        int lat, bc;
        logic [15:0] rd;
        sw[0] = 8'hA5;
        repeat (3) @(negedge clk);
        do_access(0, 2'b01, 9'h140, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h00A5) begin errors++; $display("FAIL sw_read: got %h, required 00A5", rd); end
        do_access(0, 2'b10, 9'h140, 16'hFFFF, lat, bc, rd);
        vectors++;
        if (err[0] !== 1'b0) begin errors++; $display("FAIL sw_write_err: got %b, required 0", err[0]); end
    endtask

    task automatic test_unmapped();
        int lat, bc;
        logic [15:0] rd;
        do_access(0, 2'b10, 9'h1F0, 16'hABCD, lat, bc, rd);
        vectors++;
        if (err[0] !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL unmapped_write: err=%b lat=%0d, required 1/2", err[0], lat);
        end
        do_access(0, 2'b01, 9'h1F0, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h0000 || err[0] !== 1'b1) begin
            errors++; $display("FAIL unmapped_read: rdata=%h err=%b, required 0000/1", rd, err[0]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (err[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", err[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        logic [15:0] rd;
        do_access(2, 2'b10, 9'h020, 16'h0001, lat, bc, rd);
        vectors++;
        if (lat !== 6) begin errors++; $display("FAIL ws4_latency: got %0d, required 6", lat); end
        cmd[2] = 2'b10; addr[2] = 9'h020; wdata[2] = 16'h5555;
        @(negedge clk);
        cmd[2] = 2'b00;
        @(negedge clk);
        vectors++;
        if (busy[2] !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b, required 1", busy[2]); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy[2] !== 1'b0 || ready[2] !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: busy=%b ready=%b, required 0/0", busy[2], ready[2]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_access(2, 2'b01, 9'h020, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL abort_no_write: got %h, required 0001", rd); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [15:0] rd;
        do_access(0, 2'b10, 9'h0FF, 16'hA5A5, lat, bc, rd);
        do_access(0, 2'b01, 9'h0FF, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'hA5A5) begin errors++; $display("FAIL b2b_first: got %h, required A5A5", rd); end
        do_access(0, 2'b10, 9'h0FF, 16'h5A5A, lat, bc, rd);
        do_access(0, 2'b01, 9'h0FF, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'h5A5A) begin errors++; $display("FAIL b2b_overwrite: got %h, required 5A5A", rd); end
        do_access(0, 2'b01, 9'h010, 16'h0000, lat, bc, rd);
        vectors++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL ram_retained: got %h, required BEEF", rd); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            cmd[k] = 2'b00; addr[k] = '0; wdata[k] = '0; sw[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_ram_rw();
        test_wait_states();
        test_mmio();
        test_switch();
        test_unmapped();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
